// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop deserialiser with
// framing-error reporting and a one-clock done pulse per word.
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-high reset
//   baud      oversampling tick, OVERSAMPLE ticks per bit
//   rx        serial line, idle high, asynchronous
//   rx_data   last received word, held until next rx_done
//   rx_done   one-clock pulse when rx_data/frame_err update
//   frame_err last frame's stop sample was low
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int SW = $clog2(OVERSAMPLE * STOP_BITS);
  localparam int NW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [SW-1:0]        s, s_n;
  logic [NW-1:0]        n, n_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 done_n;
  logic                 err_n;
  logic [1:0]           sync;
  logic                 rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      n         <= n_n;
      sh        <= sh_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    sh_n    = sh;
    data_n  = rx_data;
    err_n   = frame_err;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // Start edge is taken immediately, independent of baud.
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (baud) begin
          if (s == S_HALF) begin
            // Mid-start re-check rejects short glitches.
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud) begin
          if (s == S_BIT) begin
            sh_n = {rx_s, sh[DATA_BITS-1:1]};
            s_n  = '0;
            if (n == N_LAST) begin
              state_n = STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud) begin
          if (s == S_STOP) begin
            data_n  = sh;
            err_n   = ~rx_s;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick-count reference model
// compared every cycle, plus literal checks on reported frames.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DB  = 8;
  localparam int OS  = 16;
  localparam int SB  = 1;
  localparam int END_TICK = OS / 2 + DB * OS + SB * OS;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       baud  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;

  uart_rx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_BITS (SB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .baud     (baud),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit const_baud = 1'b0;

  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clock);
      bcnt = bcnt + 1;
      baud = const_baud ? 1'b1 : (bcnt % 4 == 0);
    end
  end

  // Reference model: counts baud ticks from the detected start
  // edge; the start is re-checked at tick OS/2, data bit k is
  // taken at tick OS/2 + k*OS, the stop at END_TICK.
  logic       m_s1 = 1'b1;
  logic       m_s2 = 1'b1;
  bit         m_busy = 1'b0;
  int         m_ticks = 0;
  logic [7:0] m_word = '0;
  logic [7:0] m_data = '0;
  logic       m_err = 1'b0;
  logic       m_done = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_s1   <= 1'b1;
      m_s2   <= 1'b1;
      m_busy <= 1'b0;
      m_ticks <= 0;
      m_word <= '0;
      m_data <= '0;
      m_err  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_s1   <= rx;
      m_s2   <= m_s1;
      m_done <= 1'b0;
      if (!m_busy) begin
        if (!m_s2) begin
          m_busy  <= 1'b1;
          m_ticks <= 0;
        end
      end else if (baud) begin
        m_ticks <= m_ticks + 1;
        if (m_ticks + 1 == OS / 2) begin
          if (m_s2) m_busy <= 1'b0;
        end else if (m_ticks + 1 == END_TICK) begin
          m_data <= m_word;
          m_err  <= ~m_s2;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end else if ((m_ticks + 1 - OS / 2) % OS == 0) begin
          m_word[(m_ticks + 1 - OS / 2) / OS - 1] <= m_s2;
        end
      end
    end
  end

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] q_data[$];
  logic       q_err[$];
  int         q_cyc[$];

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  task automatic pop_check(input string nm, input logic [7:0] d,
                           input logic e);
    logic [7:0] gd;
    logic       ge;
    checks++;
    if (q_data.size() == 0) begin
      fails++;
      $display("FAIL %s: no rx_done, expected data %02h err %b",
               nm, d, e);
    end else begin
      gd = q_data.pop_front();
      ge = q_err.pop_front();
      void'(q_cyc.pop_front());
      if (gd !== d || ge !== e) begin
        fails++;
        $display("FAIL %s: got data %02h err %b, expected %02h err %b",
                 nm, gd, ge, d, e);
      end
    end
  endtask

  task automatic flush();
    q_data.delete();
    q_err.delete();
    q_cyc.delete();
  endtask

  task automatic idle(input int c);
    rx = 1'b1;
    repeat (c) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input logic stop,
                      input int bp);
    rx = 1'b0;
    repeat (bp) @(negedge clock);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (bp) @(negedge clock);
    end
    rx = stop;
    repeat (bp * SB) @(negedge clock);
    rx = 1'b1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (!reset) begin
          checks++;
          if (rx_done !== m_done) begin
            fails++;
            $display("FAIL rx_done @%0d: got %b, expected %b",
                     cyc, rx_done, m_done);
          end
          checks++;
          if (rx_data !== m_data) begin
            fails++;
            $display("FAIL rx_data @%0d: got %02h, expected %02h",
                     cyc, rx_data, m_data);
          end
          checks++;
          if (frame_err !== m_err) begin
            fails++;
            $display("FAIL frame_err @%0d: got %b, expected %b",
                     cyc, frame_err, m_err);
          end
          if (rx_done) begin
            q_data.push_back(rx_data);
            q_err.push_back(frame_err);
            q_cyc.push_back(cyc);
          end
        end
      end
    join_none

    reset = 1'b1;
    repeat (3) @(negedge clock);
    lit("reset_rx_data", 32'(rx_data), 32'h0);
    lit("reset_rx_done", 32'(rx_done), 32'h0);
    lit("reset_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    idle(20);

    // 1: single frame
    send(8'hA5, 1'b1, 64);
    idle(40);
    lit("a5_count", 32'(q_data.size()), 32'd1);
    pop_check("a5", 8'hA5, 1'b0);

    // 2: start glitch then a real frame
    rx = 1'b0;
    repeat (12) @(negedge clock);
    idle(100);
    lit("glitch_no_done", 32'(q_data.size()), 32'd0);
    send(8'h3C, 1'b1, 64);
    idle(40);
    pop_check("3c", 8'h3C, 1'b0);

    // 3: bad stop, then a clean frame clears the flag
    send(8'h81, 1'b0, 64);
    idle(800);
    pop_check("81_bad_stop", 8'h81, 1'b1);
    flush();
    send(8'h7E, 1'b1, 64);
    idle(40);
    pop_check("7e", 8'h7E, 1'b0);

    // 4: asynchronous reset during data bit 4
    rx = 1'b0;
    repeat (64) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = 8'hC3 >> i;
      repeat (64) @(negedge clock);
    end
    rx = 1'b0;
    repeat (32) @(negedge clock);
    #2;
    reset = 1'b1;
    rx = 1'b1;
    #1;
    lit("async_rx_data", 32'(rx_data), 32'h0);
    lit("async_rx_done", 32'(rx_done), 32'h0);
    lit("async_frame_err", 32'(frame_err), 32'h0);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    idle(100);
    lit("c3_aborted", 32'(q_data.size()), 32'd0);
    send(8'hFF, 1'b1, 64);
    idle(40);
    pop_check("ff_after_reset", 8'hFF, 1'b0);

    // 5: back-to-back frames
    send(8'h00, 1'b1, 64);
    send(8'hFF, 1'b1, 64);
    idle(40);
    lit("b2b_count", 32'(q_data.size()), 32'd2);
    if (q_cyc.size() == 2) begin
      int gap;
      gap = q_cyc[1] - q_cyc[0];
      checks++;
      if (gap < 638 || gap > 642) begin
        fails++;
        $display("FAIL b2b_gap: got %0d clocks, expected 640+-2", gap);
      end
    end
    pop_check("b2b_00", 8'h00, 1'b0);
    pop_check("b2b_ff", 8'hFF, 1'b0);
    flush();

    // 6: baud held high, then a break condition
    const_baud = 1'b1;
    idle(20);
    send(8'h5A, 1'b1, 16);
    idle(40);
    pop_check("5a_fast", 8'h5A, 1'b0);
    rx = 1'b0;
    repeat (200) @(negedge clock);
    idle(400);
    lit("break_has_frames", 32'(q_data.size() >= 1), 32'd1);
    pop_check("break_first", 8'h00, 1'b1);
    flush();

    // random frames at full tick rate
    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send(d, 1'b1, 16);
      idle(int'($urandom_range(0, 20)));
    end
    idle(40);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
